// File: rtl/nand_pkg.sv
// Shared definitions for the NAND operation sequencer: opcodes, cycle modes,
// ONFI command bytes, sequencer states and small byte-selection helpers.
package nand_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_RESET   = 2'd3
    } op_t;

    localparam logic [1:0] MODE_CMD  = 2'd0;
    localparam logic [1:0] MODE_ADDR = 2'd1;
    localparam logic [1:0] MODE_DIN  = 2'd2;
    localparam logic [1:0] MODE_DOUT = 2'd3;

    localparam logic [7:0] CMD_READ1  = 8'h00;
    localparam logic [7:0] CMD_READ2  = 8'h30;
    localparam logic [7:0] CMD_PROG1  = 8'h80;
    localparam logic [7:0] CMD_PROG2  = 8'h10;
    localparam logic [7:0] CMD_ERASE1 = 8'h60;
    localparam logic [7:0] CMD_ERASE2 = 8'hD0;
    localparam logic [7:0] CMD_STATUS = 8'h70;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CMD1     = 4'd1,
        ADDR     = 4'd2,
        DATA_IN  = 4'd3,
        CMD2     = 4'd4,
        WAIT_WB  = 4'd5,
        WAIT_RB  = 4'd6,
        DATA_OUT = 4'd7,
        STAT_CMD = 4'd8,
        STAT_RD  = 4'd9,
        DONE     = 4'd10
    } state_t;

    // First command byte of each operation.
    function automatic logic [7:0] cmd1_byte(input op_t op);
        logic [7:0] b;
        case (op)
            OP_READ:    b = CMD_READ1;
            OP_PROGRAM: b = CMD_PROG1;
            OP_ERASE:   b = CMD_ERASE1;
            OP_RESET:   b = CMD_RESET;
            default:    b = CMD_RESET;
        endcase
        return b;
    endfunction

    // Confirm command byte; RESET has none and never reaches CMD2.
    function automatic logic [7:0] cmd2_byte(input op_t op);
        logic [7:0] b;
        case (op)
            OP_READ:    b = CMD_READ2;
            OP_PROGRAM: b = CMD_PROG2;
            OP_ERASE:   b = CMD_ERASE2;
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

    // Address byte by slot: 0-1 column low/high, 2-4 row low/mid/high.
    function automatic logic [7:0] addr_byte(input logic [2:0] idx,
                                             input logic [15:0] col,
                                             input logic [23:0] row);
        logic [7:0] b;
        case (idx)
            3'd0:    b = col[7:0];
            3'd1:    b = col[15:8];
            3'd2:    b = row[7:0];
            3'd3:    b = row[15:8];
            3'd4:    b = row[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// Two-flop synchronizer for the asynchronous NAND ready/busy line.
module nand_rb_sync (
    input  logic clk,
    input  logic nRST,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Double-register the asynchronous input to settle metastability.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/nand_op_sequencer.sv
// Expands page-level NAND operations into command/address/data cycles for
// the cycle engine, waits on ready/busy and reports completion/status.
module nand_op_sequencer
    import nand_pkg::*;
#(
    parameter int PAGE_BYTES     = 2048,
    parameter int WB_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [15:0] col_addr,
    input  logic [23:0] row_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        cyc_valid,
    input  logic        cyc_ready,
    output logic [1:0]  cyc_mode,
    output logic [7:0]  cyc_byte,
    input  logic        cyc_rvalid,
    input  logic [7:0]  cyc_rdata,
    input  logic        rb,
    output logic        done,
    output logic        done_err
);

    localparam int CNT_W = $clog2(PAGE_BYTES + 1);
    localparam int WB_W  = $clog2(WB_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAGE_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WB_W-1:0]  WB_LAST   = WB_W'(WB_CYCLES - 1);
    localparam logic [WB_W-1:0]  WB_ONE    = WB_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

    state_t            state_r, state_s;
    op_t               op_r, op_s;
    logic [15:0]       col_r, col_s;
    logic [23:0]       row_r, row_s;
    logic [2:0]        addr_idx_r, addr_idx_s;
    logic [CNT_W-1:0]  byte_cnt_r, byte_cnt_s;
    logic [WB_W-1:0]   wb_cnt_r, wb_cnt_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
    logic              rd_pend_r, rd_pend_s;
    logic              cyc_valid_r, cyc_valid_s;
    logic [1:0]        cyc_mode_r, cyc_mode_s;
    logic [7:0]        cyc_byte_r, cyc_byte_s;
    logic [7:0]        rd_data_r, rd_data_s;
    logic              rd_valid_r, rd_valid_s;
    logic              done_r, done_s;
    logic              done_err_r, done_err_s;
    logic              rb_sync_s;
    logic              hs_s;

    nand_rb_sync u_rb_sync (
        .clk      (clk),
        .nRST     (nRST),
        .async_in (rb),
        .sync_out (rb_sync_s)
    );

    // A registered cycle request completes when the engine accepts it.
    assign hs_s = cyc_valid_r && cyc_ready;

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r     <= IDLE;
            op_r        <= OP_READ;
            col_r       <= 16'h0000;
            row_r       <= 24'h000000;
            addr_idx_r  <= 3'd0;
            byte_cnt_r  <= '0;
            wb_cnt_r    <= '0;
            to_cnt_r    <= '0;
            rd_pend_r   <= 1'b0;
            cyc_valid_r <= 1'b0;
            cyc_mode_r  <= 2'd0;
            cyc_byte_r  <= 8'h00;
            rd_data_r   <= 8'h00;
            rd_valid_r  <= 1'b0;
            done_r      <= 1'b0;
            done_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            col_r       <= col_s;
            row_r       <= row_s;
            addr_idx_r  <= addr_idx_s;
            byte_cnt_r  <= byte_cnt_s;
            wb_cnt_r    <= wb_cnt_s;
            to_cnt_r    <= to_cnt_s;
            rd_pend_r   <= rd_pend_s;
            cyc_valid_r <= cyc_valid_s;
            cyc_mode_r  <= cyc_mode_s;
            cyc_byte_r  <= cyc_byte_s;
            rd_data_r   <= rd_data_s;
            rd_valid_r  <= rd_valid_s;
            done_r      <= done_s;
            done_err_r  <= done_err_s;
        end
    end

    // Next-state logic: one request per cycle, a bubble after each handshake,
    // and a single outstanding data-out cycle.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        col_s       = col_r;
        row_s       = row_r;
        addr_idx_s  = addr_idx_r;
        byte_cnt_s  = byte_cnt_r;
        wb_cnt_s    = wb_cnt_r;
        to_cnt_s    = to_cnt_r;
        rd_pend_s   = rd_pend_r;
        cyc_valid_s = cyc_valid_r;
        cyc_mode_s  = cyc_mode_r;
        cyc_byte_s  = cyc_byte_r;
        rd_data_s   = rd_data_r;
        rd_valid_s  = 1'b0;
        done_s      = 1'b0;
        done_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (op_valid) begin
                    op_s        = op_t'(op_code);
                    col_s       = col_addr;
                    row_s       = row_addr;
                    state_s     = CMD1;
                    cyc_valid_s = 1'b1;
                    cyc_mode_s  = MODE_CMD;
                    cyc_byte_s  = cmd1_byte(op_t'(op_code));
                end else begin
                    state_s = IDLE;
                end
            end
            CMD1: begin
                if (hs_s) begin
                    cyc_valid_s = 1'b0;
                    if (op_r == OP_RESET) begin
                        state_s  = WAIT_WB;
                        wb_cnt_s = '0;
                    end else begin
                        state_s    = ADDR;
                        addr_idx_s = (op_r == OP_ERASE) ? 3'd2 : 3'd0;
                    end
                end else begin
                    state_s = CMD1;
                end
            end
            ADDR: begin
                if (!cyc_valid_r) begin
                    cyc_valid_s = 1'b1;
                    cyc_mode_s  = MODE_ADDR;
                    cyc_byte_s  = addr_byte(addr_idx_r, col_r, row_r);
                end else if (hs_s) begin
                    cyc_valid_s = 1'b0;
                    if (addr_idx_r == 3'd4) begin
                        if (op_r == OP_PROGRAM) begin
                            state_s    = DATA_IN;
                            byte_cnt_s = '0;
                            cyc_mode_s = MODE_DIN;
                            cyc_byte_s = 8'h00;
                        end else begin
                            state_s = CMD2;
                        end
                    end else begin
                        addr_idx_s = addr_idx_r + 3'd1;
                    end
                end else begin
                    state_s = ADDR;
                end
            end
            DATA_IN: begin
                // Request/byte pass straight through from the write stream.
                if (wr_valid && cyc_ready) begin
                    byte_cnt_s = byte_cnt_r + CNT_ONE;
                    if (byte_cnt_r == LAST_BYTE) begin
                        state_s = CMD2;
                    end else begin
                        state_s = DATA_IN;
                    end
                end else begin
                    state_s = DATA_IN;
                end
            end
            CMD2: begin
                if (!cyc_valid_r) begin
                    cyc_valid_s = 1'b1;
                    cyc_mode_s  = MODE_CMD;
                    cyc_byte_s  = cmd2_byte(op_r);
                end else if (hs_s) begin
                    cyc_valid_s = 1'b0;
                    state_s     = WAIT_WB;
                    wb_cnt_s    = '0;
                end else begin
                    state_s = CMD2;
                end
            end
            WAIT_WB: begin
                if (wb_cnt_r == WB_LAST) begin
                    state_s  = WAIT_RB;
                    to_cnt_s = '0;
                end else begin
                    wb_cnt_s = wb_cnt_r + WB_ONE;
                end
            end
            WAIT_RB: begin
                if (rb_sync_s) begin
                    case (op_r)
                        OP_READ: begin
                            state_s    = DATA_OUT;
                            byte_cnt_s = '0;
                            rd_pend_s  = 1'b0;
                        end
                        OP_RESET: begin
                            state_s = DONE;
                            done_s  = 1'b1;
                        end
                        default: begin
                            state_s = STAT_CMD;
                        end
                    endcase
                end else if (to_cnt_r == TO_LAST) begin
                    state_s    = DONE;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else begin
                    to_cnt_s = to_cnt_r + TO_ONE;
                end
            end
            DATA_OUT: begin
                if (rd_pend_r || hs_s) begin
                    if (hs_s) begin
                        cyc_valid_s = 1'b0;
                    end else begin
                        cyc_valid_s = cyc_valid_r;
                    end
                    if (cyc_rvalid) begin
                        rd_pend_s  = 1'b0;
                        rd_data_s  = cyc_rdata;
                        rd_valid_s = 1'b1;
                        byte_cnt_s = byte_cnt_r + CNT_ONE;
                        if (byte_cnt_r == LAST_BYTE) begin
                            state_s = DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = DATA_OUT;
                        end
                    end else begin
                        rd_pend_s = 1'b1;
                    end
                end else if (!cyc_valid_r) begin
                    cyc_valid_s = 1'b1;
                    cyc_mode_s  = MODE_DOUT;
                    cyc_byte_s  = 8'h00;
                end else begin
                    state_s = DATA_OUT;
                end
            end
            STAT_CMD: begin
                if (!cyc_valid_r) begin
                    cyc_valid_s = 1'b1;
                    cyc_mode_s  = MODE_CMD;
                    cyc_byte_s  = CMD_STATUS;
                end else if (hs_s) begin
                    cyc_valid_s = 1'b0;
                    state_s     = STAT_RD;
                    rd_pend_s   = 1'b0;
                end else begin
                    state_s = STAT_CMD;
                end
            end
            STAT_RD: begin
                if (rd_pend_r || hs_s) begin
                    if (hs_s) begin
                        cyc_valid_s = 1'b0;
                    end else begin
                        cyc_valid_s = cyc_valid_r;
                    end
                    if (cyc_rvalid) begin
                        rd_pend_s  = 1'b0;
                        rd_data_s  = cyc_rdata;
                        state_s    = DONE;
                        done_s     = 1'b1;
                        done_err_s = cyc_rdata[0];
                    end else begin
                        rd_pend_s = 1'b1;
                    end
                end else if (!cyc_valid_r) begin
                    cyc_valid_s = 1'b1;
                    cyc_mode_s  = MODE_DOUT;
                    cyc_byte_s  = 8'h00;
                end else begin
                    state_s = STAT_RD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s     = IDLE;
                cyc_valid_s = 1'b0;
            end
        endcase
    end

    assign op_ready  = (state_r == IDLE) && nRST;
    assign cyc_valid = (state_r == DATA_IN) ? wr_valid : cyc_valid_r;
    assign cyc_byte  = (state_r == DATA_IN) ? wr_data  : cyc_byte_r;
    assign cyc_mode  = cyc_mode_r;
    assign wr_ready  = (state_r == DATA_IN) && cyc_ready;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign done      = done_r;
    assign done_err  = done_err_r;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer with a randomly stalling engine model.
module tb_nand_op_sequencer;

    logic        clk = 1'b0;
    logic        nRST;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [15:0] col_addr;
    logic [23:0] row_addr;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        cyc_valid;
    logic        cyc_ready;
    logic [1:0]  cyc_mode;
    logic [7:0]  cyc_byte;
    logic        cyc_rvalid;
    logic [7:0]  cyc_rdata;
    logic        rb;
    logic        done;
    logic        done_err;

    nand_op_sequencer #(
        .PAGE_BYTES     (4),
        .WB_CYCLES      (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .col_addr   (col_addr),
        .row_addr   (row_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .cyc_valid  (cyc_valid),
        .cyc_ready  (cyc_ready),
        .cyc_mode   (cyc_mode),
        .cyc_byte   (cyc_byte),
        .cyc_rvalid (cyc_rvalid),
        .cyc_rdata  (cyc_rdata),
        .rb         (rb),
        .done       (done),
        .done_err   (done_err)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc_n     = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int last_hs_cyc = 0;
    int rv_wait   = 0;
    int gap_viol  = 0;
    int gap_seen  = 0;
    logic done_err_seen = 1'b0;
    logic wr_gaps = 1'b0;
    logic [9:0] log_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] ret_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];

    // Free-running clock count used for latency checks.
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Compares the recorded cycle log against exp_q, then clears both.
    task automatic check_log(input string tag);
        chk($sformatf("%s_count", tag), log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) begin
                chk($sformatf("%s_cyc%0d", tag, i), {22'd0, log_q[i]}, {22'd0, exp_q[i]});
            end
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic start_op(input logic [1:0] op, input logic [15:0] col,
                            input logic [23:0] row, input logic [7:0] first);
        @(negedge clk);
        #2;
        chk("op_ready_idle", op_ready, 1'b1);
        op_valid = 1'b1;
        op_code  = op;
        col_addr = col;
        row_addr = row;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk("first_valid", cyc_valid, 1'b1);
        chk("first_mode", cyc_mode, 2'd0);
        chk("first_byte", cyc_byte, first);
        chk("op_ready_busy", op_ready, 1'b0);
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int base;
        base = done_cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != base) break;
        end
        chk($sformatf("%s_done", tag), done_cnt - base, 1);
        chk($sformatf("%s_err", tag), done_err_seen, exp_err);
        @(negedge clk);
        #2;
        chk($sformatf("%s_done_pulse", tag), done, 1'b0);
        chk($sformatf("%s_ready_back", tag), op_ready, 1'b1);
    endtask

    // Engine model: random ready stalls, delayed read returns, write stream.
    initial begin
        cyc_ready = 1'b0; cyc_rvalid = 1'b0; cyc_rdata = 8'h00;
        wr_valid = 1'b0; wr_data = 8'h00;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_err_seen = done_err;
                done_cyc = cyc_n;
            end
            if (rd_valid) rd_q.push_back(rd_data);
            if (!nRST) begin
                cyc_ready = 1'b0; cyc_rvalid = 1'b0; rv_wait = 0;
                ret_q.delete(); wr_valid = 1'b0;
            end else begin
                cyc_rvalid = 1'b0;
                if (rv_wait > 0) begin
                    rv_wait--;
                    if (rv_wait == 0) begin
                        cyc_rvalid = 1'b1;
                        cyc_rdata  = (ret_q.size() > 0) ? ret_q.pop_front() : 8'hEE;
                    end
                end
                wr_valid  = (wr_q.size() > 0) && (!wr_gaps || ($urandom_range(0, 2) != 0));
                wr_data   = wr_valid ? wr_q[0] : 8'h00;
                cyc_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (wr_gaps && !wr_valid && wr_q.size() > 0 && dut.state_r == nand_pkg::DATA_IN) gap_seen++;
                if (wr_gaps && !wr_valid && cyc_valid && cyc_mode == 2'd2) gap_viol++;
                if (cyc_valid && cyc_ready) begin
                    log_q.push_back({cyc_mode, cyc_byte});
                    last_hs_cyc = cyc_n;
                    if (cyc_mode == 2'd3) rv_wait = $urandom_range(1, 3);
                    if (cyc_mode == 2'd2 && wr_q.size() > 0) void'(wr_q.pop_front());
                end
            end
        end
    end

    // Overall time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; op_valid = 1'b0; op_code = 2'd0;
        col_addr = 16'h0000; row_addr = 24'h000000; rb = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_op_ready", op_ready, 1'b0);
        chk("rst_cyc_valid", cyc_valid, 1'b0);
        chk("rst_cyc_mode", cyc_mode, 2'd0);
        chk("rst_cyc_byte", cyc_byte, 8'h00);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_done_err", done_err, 1'b0);
        nRST = 1'b1;
        @(negedge clk);
        #2;
        chk("rel_op_ready", op_ready, 1'b1);

        // RESET: busy for 10 clocks, then ready.
        start_op(2'd3, 16'h0000, 24'h000000, 8'hFF);
        repeat (10) @(negedge clk);
        rb = 1'b1;
        wait_done("reset", 1'b0);
        exp_q = '{{2'd0, 8'hFF}};
        check_log("reset_log");

        // READ col 0x0123 row 0x045678.
        ret_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rd_q.delete();
        start_op(2'd0, 16'h0123, 24'h045678, 8'h00);
        wait_done("read", 1'b0);
        exp_q = '{{2'd0, 8'h00}, {2'd1, 8'h23}, {2'd1, 8'h01}, {2'd1, 8'h78}, {2'd1, 8'h56},
                  {2'd1, 8'h04}, {2'd0, 8'h30}, {2'd3, 8'h00}, {2'd3, 8'h00}, {2'd3, 8'h00},
                  {2'd3, 8'h00}};
        check_log("read_log");
        chk("read_nbytes", rd_q.size(), 4);
        if (rd_q.size() == 4) begin
            chk("read_b0", rd_q[0], 8'hAA);
            chk("read_b1", rd_q[1], 8'hBB);
            chk("read_b2", rd_q[2], 8'hCC);
            chk("read_b3", rd_q[3], 8'hDD);
        end
        rd_q.delete();

        // PROGRAM row 0x000102, status pass then status fail.
        for (int k = 0; k < 2; k++) begin
            wr_q  = '{8'h11, 8'h22, 8'h33, 8'h44};
            ret_q = '{(k == 0) ? 8'h00 : 8'h01};
            start_op(2'd1, 16'h0000, 24'h000102, 8'h80);
            wait_done($sformatf("prog%0d", k), (k == 0) ? 1'b0 : 1'b1);
            chk("prog_status_data", rd_data, (k == 0) ? 8'h00 : 8'h01);
            chk("prog_no_rd_valid", rd_q.size(), 0);
            exp_q = '{{2'd0, 8'h80}, {2'd1, 8'h00}, {2'd1, 8'h00}, {2'd1, 8'h02}, {2'd1, 8'h01},
                      {2'd1, 8'h00}, {2'd2, 8'h11}, {2'd2, 8'h22}, {2'd2, 8'h33}, {2'd2, 8'h44},
                      {2'd0, 8'h10}, {2'd0, 8'h70}, {2'd3, 8'h00}};
            check_log($sformatf("prog%0d_log", k));
        end

        // PROGRAM with gaps in the write stream.
        wr_gaps = 1'b1;
        gap_viol = 0;
        gap_seen = 0;
        wr_q  = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        ret_q = '{8'h00};
        start_op(2'd1, 16'h0000, 24'h000102, 8'h80);
        wait_done("gap", 1'b0);
        wr_gaps = 1'b0;
        chk("gap_no_din_while_idle", gap_viol, 0);
        chk("gap_exercised", gap_seen > 0, 1'b1);
        exp_q = '{{2'd0, 8'h80}, {2'd1, 8'h00}, {2'd1, 8'h00}, {2'd1, 8'h02}, {2'd1, 8'h01},
                  {2'd1, 8'h00}, {2'd2, 8'h5A}, {2'd2, 8'hA5}, {2'd2, 8'h3C}, {2'd2, 8'hC3},
                  {2'd0, 8'h10}, {2'd0, 8'h70}, {2'd3, 8'h00}};
        check_log("gap_log");

        // ERASE with rb stuck busy: timeout 64 clocks after WAIT_RB entry.
        rb = 1'b0;
        start_op(2'd2, 16'h1234, 24'hABCDEF, 8'h60);
        wait_done("erase_to", 1'b1);
        chk("erase_to_latency", done_cyc - last_hs_cyc, 69);
        exp_q = '{{2'd0, 8'h60}, {2'd1, 8'hEF}, {2'd1, 8'hCD}, {2'd1, 8'hAB}, {2'd0, 8'hD0}};
        check_log("erase_log");
        rb = 1'b1;

        // Reset in the middle of DATA_OUT, then a clean READ.
        begin
            int base_done;
            logic found;
            found = 1'b0;
            base_done = done_cnt;
            ret_q = '{8'h01, 8'h02, 8'h03, 8'h04};
            start_op(2'd0, 16'h0123, 24'h045678, 8'h00);
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                #2;
                if (log_q.size() >= 8) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("mid_reached_dout", found, 1'b1);
            #1;
            nRST = 1'b0;
            #1;
            chk("mid_cyc_valid", cyc_valid, 1'b0);
            chk("mid_cyc_mode", cyc_mode, 2'd0);
            chk("mid_cyc_byte", cyc_byte, 8'h00);
            chk("mid_rd_valid", rd_valid, 1'b0);
            chk("mid_rd_data", rd_data, 8'h00);
            chk("mid_done", done, 1'b0);
            chk("mid_op_ready", op_ready, 1'b0);
            repeat (3) @(negedge clk);
            #2;
            nRST = 1'b1;
            @(negedge clk);
            #2;
            chk("mid_ready_after", op_ready, 1'b1);
            chk("mid_no_done", done_cnt - base_done, 0);
            log_q.delete();
            rd_q.delete();
        end
        ret_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        start_op(2'd0, 16'h0123, 24'h045678, 8'h00);
        wait_done("reread", 1'b0);
        chk("reread_nbytes", rd_q.size(), 4);
        if (rd_q.size() == 4) begin
            chk("reread_b0", rd_q[0], 8'h9A);
            chk("reread_b3", rd_q[3], 8'hF0);
        end
        exp_q = '{{2'd0, 8'h00}, {2'd1, 8'h23}, {2'd1, 8'h01}, {2'd1, 8'h78}, {2'd1, 8'h56},
                  {2'd1, 8'h04}, {2'd0, 8'h30}, {2'd3, 8'h00}, {2'd3, 8'h00}, {2'd3, 8'h00},
                  {2'd3, 8'h00}};
        check_log("reread_log");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
